// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: collects slots 0..3 delimited by frame_sync and
// publishes whole frames on y0..y3. Optional framing checks under TDM_DEMUX_SYNC_CHECK_EN.
module tdm_demux4 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             frame_sync,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3,
   output logic             frame_valid,
   output logic [1:0]       sel,
   output logic             locked,
   output logic             sync_err
);

   typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [1:0]       sel_q, sel_d;
   logic [WIDTH-1:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
   logic [WIDTH-1:0] y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
   logic             fv_q, fv_d;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
   logic             err_q, err_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
         sel_q   <= 2'd0;
         s0_q    <= '0;
         s1_q    <= '0;
         s2_q    <= '0;
         y0_q    <= '0;
         y1_q    <= '0;
         y2_q    <= '0;
         y3_q    <= '0;
         fv_q    <= 1'b0;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         s0_q    <= s0_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         y0_q    <= y0_d;
         y1_q    <= y1_d;
         y2_q    <= y2_d;
         y3_q    <= y3_d;
         fv_q    <= fv_d;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   // Slot routing and framing; nothing moves on a beat without din_valid.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      s0_d    = s0_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      y0_d    = y0_q;
      y1_d    = y1_q;
      y2_d    = y2_q;
      y3_d    = y3_q;
      fv_d    = 1'b0;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
      err_d   = 1'b0;
`endif
      if (din_valid) begin
         case (state_q)
            HUNT: begin
               if (frame_sync) begin
                  s0_d    = din;
                  sel_d   = 2'd1;
                  state_d = LOCK;
               end
            end
            LOCK: begin
               if (frame_sync) begin
                  // A sync beat always restarts the frame; a mid-frame one drops the partial frame.
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                  err_d = (sel_q != 2'd0);
`endif
                  s0_d  = din;
                  sel_d = 2'd1;
               end else begin
                  case (sel_q)
                     2'd0: begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
                        err_d   = 1'b1;
                        state_d = HUNT;
                        sel_d   = 2'd0;
`else
                        s0_d    = din;
                        sel_d   = 2'd1;
`endif
                     end
                     2'd1: begin
                        s1_d  = din;
                        sel_d = 2'd2;
                     end
                     2'd2: begin
                        s2_d  = din;
                        sel_d = 2'd3;
                     end
                     default: begin
                        y0_d  = s0_q;
                        y1_d  = s1_q;
                        y2_d  = s2_q;
                        y3_d  = din;
                        fv_d  = 1'b1;
                        sel_d = 2'd0;
                     end
                  endcase
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   assign y0          = y0_q;
   assign y1          = y1_q;
   assign y2          = y2_q;
   assign y3          = y3_q;
   assign frame_valid = fv_q;
   assign sel         = sel_q;
   assign locked      = (state_q == LOCK);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
   assign sync_err    = err_q;
`else
   assign sync_err    = 1'b0;
`endif

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive end of the 4:1 select-line multiplexer path. It takes one WIDTH-bit TDM stream whose frames are marked by `frame_sync` and routes slots 0..3 to registered outputs `y0..y3`. It presents a complete, coherent frame with a one-cycle `frame_valid` pulse. It sits between the serial link/mux output and the per-channel consumers.

## Interface
- `WIDTH`, default 1: bit width of each slot and of each output channel.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; **asynchronous, active-low**.
- `din`  in  WIDTH  slot data.
- `din_valid`  in  1  `din` carries a slot this cycle; no progress while low.
- `frame_sync`  in  1  qualified by `din_valid`; marks the current beat as slot 0.
- `y0`, `y1`, `y2`, `y3`  out  WIDTH  channel outputs; hold the last complete frame.
- `frame_valid`  out  1  one-cycle pulse when `y0..y3` update.
- `sel`  out  2  slot index expected on the next valid beat.
- `locked`  out  1  high in LOCK state.
- `sync_err`  out  1  one-cycle pulse on a framing violation (see Configuration).

## Operation
- States: HUNT (reset state) and LOCK. `locked` is 1 only in LOCK.
- Slot counter `sel`: 2-bit, wraps 3 -> 0.
- Shadow registers s0..s2 collect a frame in progress. Outputs change only at frame completion.
- HUNT:
  - Beats with `din_valid`=1 and `frame_sync`=0 are discarded.
  - On `din_valid`=1 and `frame_sync`=1: `din` goes to s0, `sel` becomes 1, next state is LOCK.
- LOCK, beat with `din_valid`=1:
  - Slots 1 and 2: `din` goes to s[sel]; `sel` increments.
  - Slot 3: y0<=s0, y1<=s1, y2<=s2, y3<=`din`, all in the same edge. `frame_valid` pulses. `sel` goes to 0.
  - Slot 0 with `frame_sync`=1: normal start of frame. `din` goes to s0; `sel` becomes 1.
- `din_valid`=0: state, `sel`, shadows and outputs hold. `frame_valid` is 0.
- Early sync (`frame_sync`=1 while `sel`≠0 in LOCK):
  - The partial frame is discarded; y0..y3 are untouched.
  - The beat is taken as slot 0: `din` goes to s0, `sel` becomes 1, state stays LOCK.
- Missing sync (LOCK, `sel`=0, `din_valid`=1, `frame_sync`=0): behaviour set by the macro below.
- Reset values: y0..y3=0, `frame_valid`=0, `sel`=0, `locked`=0, `sync_err`=0, shadows=0, state HUNT.
- Reset asserted mid-frame clears everything immediately. The partial frame is lost, and `frame_valid` does not pulse for it.

## Timing
- All outputs are registered.
- A slot-3 beat sampled at edge N drives y0..y3 updated and `frame_valid`=1 during cycle N+1, i.e. 1-cycle latency. `frame_valid` returns to 0 after one cycle unless another frame completes.
- Back-to-back frames with `din_valid` held high give one `frame_valid` every 4 cycles.
- `sync_err` pulses for one cycle, in the cycle after the offending beat.
- `locked` rises in the cycle after the first sync beat is sampled.
- No combinational path from inputs to outputs.

## Configuration
- Macro: `TDM_DEMUX_SYNC_CHECK_EN`.
- Defined:
  - Early sync pulses `sync_err`, then resyncs as described in Operation.
  - Missing sync pulses `sync_err`, discards the beat, and returns to HUNT with `sel`=0. y0..y3 hold.
- Undefined:
  - `sync_err` is tied to 0.
  - Early sync resyncs silently.
  - Missing sync is ignored: the beat is accepted as slot 0, and the block free-runs in LOCK.

## Test plan
- **Reset:** assert `rst_n`=0 mid-frame. All outputs read 0, `locked`=0; no `frame_valid` after release until a new sync frame arrives.
- **Basic frame (WIDTH=1):** sync frame with `din`=1,0,0,0 then 0,1,0,0. Two `frame_valid` pulses, 4 cycles apart; y0..y3 read 1,0,0,0 then 0,1,0,0. Covers the `sel` wrap.
- **Gaps (WIDTH=4):** `din_valid` low for 3 cycles between slots 1 and 2 of frame A,B,C,D. The single `frame_valid` comes 1 cycle after slot 3; y0..y3 = A,B,C,D; `sel` holds at 2 during the gap.
- **Early sync:** `frame_sync` on slot 2. With the macro: `sync_err` pulses once, the old y values persist, and the next frame completes correctly. Without the macro: `sync_err` stays 0, same data result.
- **Missing sync:** slot-0 beat with `frame_sync`=0. With the macro: `sync_err` pulses, `locked` drops to 0, and no frame is produced until the next sync. Without the macro: the frame completes with that beat in y0.
- **HUNT filtering:** 5 valid beats without sync after reset. `frame_valid` never pulses; `locked` stays 0.
